// File: rtl/pred_tx6_pkg.sv
// rtl/pred_tx6_pkg.sv - shared constants, destination bit positions and FSM states for pred_tx6
package pred_tx6_pkg;

    localparam int PRED_W_DEF  = 4;
    localparam int ADDR_W_DEF  = 6;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 15;

    // Destination mask layout {edge5, edge7, edge10, bus}
    localparam int DST_W      = 4;
    localparam int DST_EDGE5  = 3;
    localparam int DST_EDGE7  = 2;
    localparam int DST_EDGE10 = 1;
    localparam int DST_BUS    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage

// File: rtl/pred_tx6_cmd_fifo.sv
// rtl/pred_tx6_cmd_fifo.sv - synchronous command FIFO of {addr, dst} with wrap-bit pointers
module pred_tx6_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push while full is refused even if a pop happens in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are meaningless while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pred_tx6.sv
// rtl/pred_tx6.sv - PE6 predicate transmitter (optional abort timer under PRED_TX_TIMEOUT_EN)
module pred_tx6
    import pred_tx6_pkg::*;
#(
    parameter int PRED_W  = PRED_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
`ifdef PRED_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_dst,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PRED_W-1:0] rd_data,
    output logic [PRED_W-1:0] edge5_p_out,
    output logic [PRED_W-1:0] edge7_p_out,
    output logic [PRED_W-1:0] edge10_p_out,
    output logic [PRED_W-1:0] bus_p_out,
    output logic              edge5_p_vld,
    output logic              edge7_p_vld,
    output logic              edge10_p_vld,
    output logic              bus_p_vld,
    input  logic              edge5_p_ack,
    input  logic              edge7_p_ack,
    input  logic              edge10_p_ack,
    input  logic              bus_p_ack,
    output logic              busy,
    output logic              tx_err
);

    localparam int CMD_W = ADDR_W + DST_W;

    state_t             state;
    state_t             next_state;
    logic [PRED_W-1:0]  data_q;
    logic [DST_W-1:0]   pending;
    logic [DST_W-1:0]   pending_nxt;
    logic [DST_W-1:0]   vld;
    logic [DST_W-1:0]   ack;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CMD_W-1:0]   fifo_head;
    logic [ADDR_W-1:0]  head_addr;
    logic [DST_W-1:0]   head_dst;
    logic               timeout_hit;

    assign cmd_ready             = !fifo_full;
    assign fifo_push             = cmd_valid && !fifo_full;
    assign {head_addr, head_dst} = fifo_head;
    assign busy                  = (state != ST_IDLE) || !fifo_empty;

    pred_tx6_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({cmd_addr, cmd_dst}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // A destination is offered data only while SEND still owes it a handshake;
    // acks on destinations that are not valid fall out of the mask here.
    assign ack         = {edge5_p_ack, edge7_p_ack, edge10_p_ack, bus_p_ack};
    assign vld         = (state == ST_SEND) ? pending : '0;
    assign pending_nxt = pending & ~(vld & ack);

    assign edge5_p_vld  = vld[DST_EDGE5];
    assign edge7_p_vld  = vld[DST_EDGE7];
    assign edge10_p_vld = vld[DST_EDGE10];
    assign bus_p_vld    = vld[DST_BUS];
    assign edge5_p_out  = vld[DST_EDGE5]  ? data_q : '0;
    assign edge7_p_out  = vld[DST_EDGE7]  ? data_q : '0;
    assign edge10_p_out = vld[DST_EDGE10] ? data_q : '0;
    assign bus_p_out    = vld[DST_BUS]    ? data_q : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next state, FIFO pop and register-file read address
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        rd_addr    = '0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) next_state = ST_READ;
            end
            ST_READ: begin
                rd_addr    = head_addr;
                fifo_pop   = 1'b1;
                next_state = (head_dst != '0) ? ST_SEND : ST_IDLE;
            end
            ST_SEND: begin
                if ((pending_nxt == '0) || timeout_hit) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Capture the predicate and target mask in READ; retire acked targets in SEND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            pending <= '0;
        end else if (state == ST_READ) begin
            data_q  <= rd_data;
            pending <= head_dst;
        end else if (state == ST_SEND) begin
            pending <= timeout_hit ? '0 : pending_nxt;
        end
    end

`ifdef PRED_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            tx_err_q;

    // to_cnt holds the number of SEND cycles already completed, so the abort
    // lands at the end of the TIMEOUT-th SEND cycle if targets are still owed.
    assign timeout_hit = (state == ST_SEND) && (pending_nxt != '0) &&
                         (to_cnt == TO_W'(TIMEOUT - 1));
    assign tx_err      = tx_err_q;

    // SEND cycle counter, restarted on the way into SEND, and the error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt   <= '0;
            tx_err_q <= 1'b0;
        end else begin
            tx_err_q <= timeout_hit;
            if (state == ST_READ)      to_cnt <= '0;
            else if (state == ST_SEND) to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign tx_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pred_tx6.sv
// tb/tb_pred_tx6.sv - self-checking bench for pred_tx6 (table vectors, directed sequences, random traffic)
module tb_pred_tx6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [5:0] cmd_addr;
    logic [3:0] cmd_dst;
    logic [5:0] rd_addr;
    logic [3:0] rd_data;
    logic [3:0] edge5_p_out, edge7_p_out, edge10_p_out, bus_p_out;
    logic       edge5_p_vld, edge7_p_vld, edge10_p_vld, bus_p_vld;
    logic       edge5_p_ack, edge7_p_ack, edge10_p_ack, bus_p_ack;
    logic       busy;
    logic       tx_err;
    logic [3:0] ack_v;
    logic [3:0] vld_v;
    logic [3:0] regs [64];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];
    assign {edge5_p_ack, edge7_p_ack, edge10_p_ack, bus_p_ack} = ack_v;
    assign vld_v = {edge5_p_vld, edge7_p_vld, edge10_p_vld, bus_p_vld};

    pred_tx6 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_dst      (cmd_dst),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .edge5_p_out  (edge5_p_out),
        .edge7_p_out  (edge7_p_out),
        .edge10_p_out (edge10_p_out),
        .bus_p_out    (bus_p_out),
        .edge5_p_vld  (edge5_p_vld),
        .edge7_p_vld  (edge7_p_vld),
        .edge10_p_vld (edge10_p_vld),
        .bus_p_vld    (bus_p_vld),
        .edge5_p_ack  (edge5_p_ack),
        .edge7_p_ack  (edge7_p_ack),
        .edge10_p_ack (edge10_p_ack),
        .bus_p_ack    (bus_p_ack),
        .busy         (busy),
        .tx_err       (tx_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per destination, the ordered list of predicates it must receive
    logic [3:0] q3[$], q2[$], q1[$], q0[$];

    function automatic void qpush(int i, logic [3:0] v);
        case (i)
            3: q3.push_back(v);
            2: q2.push_back(v);
            1: q1.push_back(v);
            default: q0.push_back(v);
        endcase
    endfunction

    function automatic int qsize(int i);
        case (i)
            3: return q3.size();
            2: return q2.size();
            1: return q1.size();
            default: return q0.size();
        endcase
    endfunction

    function automatic logic [3:0] qpop(int i);
        case (i)
            3: return q3.pop_front();
            2: return q2.pop_front();
            1: return q1.pop_front();
            default: return q0.pop_front();
        endcase
    endfunction

    function automatic void qclear();
        q3.delete(); q2.delete(); q1.delete(); q0.delete();
    endfunction

    function automatic logic [3:0] pout(int i);
        case (i)
            3: return edge5_p_out;
            2: return edge7_p_out;
            1: return edge10_p_out;
            default: return bus_p_out;
        endcase
    endfunction

    // Monitor: handshakes must deliver the next expected value, idle lanes must read 0
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (vld_v[i]) begin
                    if (ack_v[i]) begin
                        if (qsize(i) == 0) chk("mon_unexpected_delivery", i, -1);
                        else               chk("mon_data", pout(i), qpop(i));
                    end
                end else begin
                    chk("mon_pout_zero_when_invalid", pout(i), 0);
                end
            end
`ifndef PRED_TX_TIMEOUT_EN
            chk("mon_tx_err_low", tx_err, 0);
`endif
            if (cmd_valid && cmd_ready) begin
                for (int i = 0; i < 4; i++)
                    if (cmd_dst[i]) qpush(i, regs[cmd_addr]);
            end
        end
    end

    task automatic push_cmd(input logic [5:0] a, input logic [3:0] d);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_dst = d;
        @(negedge clk);
        chk("push_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, busy, 0);
    endtask

    typedef struct {
        logic [5:0] addr;
        logic [3:0] dst;
        logic [3:0] data;
        logic [3:0] exp_vld;
        logic [3:0] exp_e5;
        logic [3:0] exp_e7;
        logic [3:0] exp_e10;
        logic [3:0] exp_bus;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, held, errs, w, accepted;
        logic [3:0] exp;

        vecs[0] = '{6'd5,  4'b1000, 4'hA, 4'b1000, 4'hA, 4'h0, 4'h0, 4'h0};
        vecs[1] = '{6'd9,  4'b0101, 4'h3, 4'b0101, 4'h0, 4'h3, 4'h0, 4'h3};
        vecs[2] = '{6'd63, 4'b0010, 4'hF, 4'b0010, 4'h0, 4'h0, 4'hF, 4'h0};
        vecs[3] = '{6'd0,  4'b0000, 4'h7, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[4] = '{6'd33, 4'b1111, 4'h6, 4'b1111, 4'h6, 4'h6, 4'h6, 4'h6};
        vecs[5] = '{6'd12, 4'b0001, 4'h0, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0};

        for (int i = 0; i < 64; i++) regs[i] = 4'($urandom);
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_dst = '0; ack_v = '0;

        // Reset state
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_vld", vld_v, 0);
        chk("rst_tx_err", tx_err, 0);
        chk("rst_rd_addr", rd_addr, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table vectors: single command, acks held high
        ack_v = 4'hF;
        for (int v = 0; v < 6; v++) begin
            regs[vecs[v].addr] = vecs[v].data;
            push_cmd(vecs[v].addr, vecs[v].dst);
            @(negedge clk);
            chk("tbl_idle_vld", vld_v, 0);
            @(negedge clk);
            chk("tbl_read_rd_addr", rd_addr, vecs[v].addr);
            chk("tbl_read_busy", busy, 1);
            chk("tbl_read_vld", vld_v, 0);
            @(negedge clk);
            chk("tbl_send_vld", vld_v, vecs[v].exp_vld);
            chk("tbl_send_e5", edge5_p_out, vecs[v].exp_e5);
            chk("tbl_send_e7", edge7_p_out, vecs[v].exp_e7);
            chk("tbl_send_e10", edge10_p_out, vecs[v].exp_e10);
            chk("tbl_send_bus", bus_p_out, vecs[v].exp_bus);
            chk("tbl_send_rd_addr", rd_addr, 0);
            @(negedge clk);
            chk("tbl_done_vld", vld_v, 0);
            chk("tbl_done_busy", busy, 0);
        end

        // Staggered acks: bus at +1, edge7 at +3, edge5/edge10 at +5; stray bus ack at +3
        ack_v = 4'h0;
        regs[9] = 4'h3;
        push_cmd(6'd9, 4'b1111);
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k <= 6; k++) begin
            ack_v[0] = (k == 1) || (k == 3);
            ack_v[2] = (k == 3);
            ack_v[3] = (k == 5);
            ack_v[1] = (k == 5);
            exp = {k <= 5, k <= 3, k <= 5, k <= 1};
            @(negedge clk);
            chk("stag_vld", vld_v, exp);
            chk("stag_busy", busy, (k <= 5) ? 1 : 0);
            @(posedge clk); #1;
        end
        ack_v = 4'h0;

        // Five back-to-back commands with no acks fill the FIFO behind the one in SEND
        for (int k = 0; k < 5; k++) regs[10 + k] = 4'(k + 1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; cmd_addr = 6'(10 + k); cmd_dst = 4'b1111;
            @(negedge clk);
            chk("b2b_ready", cmd_ready, 1);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("b2b_full_ready", cmd_ready, 0);
            chk("b2b_full_busy", busy, 1);
        end
        @(posedge clk); #1 ack_v = 4'hF;
        cyc = 0;
        do begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end while (busy && cyc < 50);
        chk("b2b_drain_cycles", cyc, 13);
        chk("b2b_model_empty", qsize(0) + qsize(1) + qsize(2) + qsize(3), 0);

        // Reset in the middle of SEND with two commands still queued
        ack_v = 4'h0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_addr = 6'(40 + k); cmd_dst = 4'b1011;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_in_send", vld_v, 4'b1011);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rstmid_vld", vld_v, 0);
        chk("rstmid_pout", {edge5_p_out, edge7_p_out, edge10_p_out, bus_p_out}, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", cmd_ready, 1);
        qclear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_v = 4'hF;
        repeat (5) begin
            @(negedge clk);
            chk("rstmid_after_busy", busy, 0);
            chk("rstmid_after_vld", vld_v, 0);
        end

        // No acknowledge at all: hold forever, or abort after the timeout when enabled
        ack_v = 4'h0;
        regs[20] = 4'h9;
        push_cmd(6'd20, 4'b0100);
        w = 0;
        @(negedge clk);
        while (!edge7_p_vld && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("to_vld_seen", edge7_p_vld, 1);
        held = 1; errs = 0;
        repeat (40) begin
            @(negedge clk);
            if (edge7_p_vld) held++;
            if (tx_err) errs++;
        end
`ifdef PRED_TX_TIMEOUT_EN
        chk("to_vld_cycles", held, 15);
        chk("to_err_pulses", errs, 1);
        chk("to_busy_after", busy, 0);
        qclear();
`else
        chk("to_vld_held", held, 41);
        chk("to_no_err", errs, 0);
        @(posedge clk); #1 ack_v = 4'hF;
        wait_idle(20, "to_release_idle");
`endif

        // Random traffic against the per-destination delivery model
        accepted = 0; cyc = 0;
        while (accepted < 60 && cyc < 3000) begin
            @(posedge clk); #1;
            ack_v     = 4'($urandom);
            cmd_valid = 1'($urandom);
            cmd_addr  = 6'($urandom);
            cmd_dst   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            @(negedge clk);
            if (cmd_valid && cmd_ready) accepted++;
            cyc++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ack_v = 4'hF;
        chk("rand_accepted", accepted, 60);
        wait_idle(400, "rand_drain_idle");
        chk("rand_model_empty", qsize(0) + qsize(1) + qsize(2) + qsize(3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
